// File: rtl/mem_arb_pkg.sv
// Shared encodings and defaults for the two-master simple_ram arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'b00,
        OWN_M0   = 2'b01,
        OWN_M1   = 2'b10
    } owner_e;

    localparam int MAX_HOLD_DEFAULT = 4;

    // Encoding of the "last served" bit; reset favours M0 by pretending M1 went last.
    localparam logic LAST_M0 = 1'b0;
    localparam logic LAST_M1 = 1'b1;

    function automatic int hold_cnt_width(input int max_hold);
        return $clog2(max_hold) + 1;
    endfunction

endpackage

// File: rtl/mem_arb_fsm.sv
// Ownership state machine: owner, last-served and hold counter with round-robin
// tie-break and a bounded run length while the other master waits.
module mem_arb_fsm
    import mem_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       m0_req_i,
    input  logic       m1_req_i,
    output logic [1:0] owner_o
);

    localparam int HCW = hold_cnt_width(MAX_HOLD);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [HCW-1:0] HOLD_SAT  = {HCW{1'b1}};

    owner_e         owner_q, owner_d;
    logic           last_q, last_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;

    logic m0_served, m1_served;
    logic [HCW-1:0] hold_inc;

    assign m0_served = m0_req_i && (owner_q == OWN_M0);
    assign m1_served = m1_req_i && (owner_q == OWN_M1);
    assign hold_inc  = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= OWN_IDLE;
            last_q     <= LAST_M1;
            hold_cnt_q <= '0;
        end else begin
            owner_q    <= owner_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    always_comb begin
        owner_d    = owner_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;

        if (m0_served) begin
            last_d = LAST_M0;
        end else if (m1_served) begin
            last_d = LAST_M1;
        end

        case (owner_q)
            OWN_IDLE: begin
                hold_cnt_d = '0;
                if (m0_req_i && m1_req_i) begin
                    owner_d = (last_q == LAST_M1) ? OWN_M0 : OWN_M1;
                end else if (m0_req_i) begin
                    owner_d = OWN_M0;
                end else if (m1_req_i) begin
                    owner_d = OWN_M1;
                end
            end
            OWN_M0: begin
                // The run is cut only when the other side is actually waiting.
                if (m0_req_i && (!m1_req_i || (hold_cnt_q < HOLD_LAST))) begin
                    hold_cnt_d = hold_inc;
                end else if (m1_req_i) begin
                    owner_d    = OWN_M1;
                    hold_cnt_d = '0;
                end else begin
                    owner_d    = OWN_IDLE;
                    hold_cnt_d = '0;
                end
            end
            OWN_M1: begin
                if (m1_req_i && (!m0_req_i || (hold_cnt_q < HOLD_LAST))) begin
                    hold_cnt_d = hold_inc;
                end else if (m0_req_i) begin
                    owner_d    = OWN_M0;
                    hold_cnt_d = '0;
                end else begin
                    owner_d    = OWN_IDLE;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                owner_d    = OWN_IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    assign owner_o = owner_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-master front end for simple_ram's single data port: muxes the owning
// master onto the memory bus and generates per-master ready.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_HOLD   = MAX_HOLD_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    m0_req,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_wenable,
    output logic                    m0_ready,
    output logic [DATA_WIDTH-1:0]   m0_rdata,

    input  logic                    m1_req,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wenable,
    output logic                    m1_ready,
    output logic [DATA_WIDTH-1:0]   m1_rdata,

    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wenable,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,

    output logic [1:0]              owner
);

    logic [1:0] owner_q;

    mem_arb_fsm #(
        .MAX_HOLD (MAX_HOLD)
    ) u_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_req_i (m0_req),
        .m1_req_i (m1_req),
        .owner_o  (owner_q)
    );

    assign owner    = owner_q;
    assign m0_ready = m0_req && (owner_q == OWN_M0);
    assign m1_ready = m1_req && (owner_q == OWN_M1);

    // Both masters see the RAM read port directly; ready qualifies it.
    assign m0_rdata = mem_rdata;
    assign m1_rdata = mem_rdata;

    // Write enables are gated by ready so a dropped request or reset never writes.
    always_comb begin
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_wenable = '0;
        case (owner_q)
            OWN_M0: begin
                mem_addr    = m0_addr;
                mem_wdata   = m0_wdata;
                mem_wenable = m0_ready ? m0_wenable : '0;
            end
            OWN_M1: begin
                mem_addr    = m1_addr;
                mem_wdata   = m1_wdata;
                mem_wenable = m1_ready ? m1_wenable : '0;
            end
            default: begin
                mem_addr    = '0;
                mem_wdata   = '0;
                mem_wenable = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a small behavioural simple_ram.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic [3:0]  m0_wenable = '0, m1_wenable = '0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wenable;
    logic [1:0]  owner;

    logic        h1_m0_ready, h1_m1_ready;
    logic [31:0] h1_m0_rdata, h1_m1_rdata;
    logic [31:0] h1_mem_addr, h1_mem_wdata;
    logic [31:0] h1_mem_rdata = 32'h0;
    logic [3:0]  h1_mem_wenable;
    logic [1:0]  h1_owner;

    logic [31:0] ram [0:15];

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0]  exp_grant_q[$];
    logic [31:0] exp_data_q[$];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wenable(m0_wenable),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wenable(m1_wenable),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wenable(mem_wenable),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_HOLD(1)) dut_h1 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wenable(m0_wenable),
        .m0_ready(h1_m0_ready), .m0_rdata(h1_m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wenable(m1_wenable),
        .m1_ready(h1_m1_ready), .m1_rdata(h1_m1_rdata),
        .mem_addr(h1_mem_addr), .mem_wdata(h1_mem_wdata), .mem_wenable(h1_mem_wenable),
        .mem_rdata(h1_mem_rdata), .owner(h1_owner)
    );

    // simple_ram model: 16 words, combinational read, byte-enabled write
    assign mem_rdata = ram[mem_addr[5:2]];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_wenable[b]) ram[mem_addr[5:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    task automatic wait_edge;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle;
        m0_req = 1'b0; m1_req = 1'b0;
        m0_wenable = '0; m1_wenable = '0;
        wait_edge;
        wait_edge;
    endtask

    task automatic do_reset;
        m0_req = 1'b0; m1_req = 1'b0;
        m0_wenable = '0; m1_wenable = '0;
        rst_n = 1'b0;
        wait_edge;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        m0_req = 1'b1; m0_addr = 32'd4; m0_wdata = 32'hCAFEF00D; m0_wenable = 4'hF;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (mem_wenable !== 4'h0) begin n_bad++; $display("FAIL rst_wen: got %h want 0", mem_wenable); end
            n_cmp++; if (m0_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", m0_ready); end
            n_cmp++; if (owner !== 2'b00) begin n_bad++; $display("FAIL rst_owner: got %b want 00", owner); end
            n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        end
        wait_edge;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (owner !== 2'b00) begin n_bad++; $display("FAIL rel_owner0: got %b want 00", owner); end
        wait_edge;
        @(negedge clk);
        n_cmp++; if (owner !== 2'b01) begin n_bad++; $display("FAIL rel_owner1: got %b want 01", owner); end
        n_cmp++; if (m0_ready !== 1'b1) begin n_bad++; $display("FAIL rel_ready: got %b want 1", m0_ready); end
        wait_edge;
        m0_req = 1'b0; m0_wenable = '0;
        @(negedge clk);
        n_cmp++; if (ram[1] !== 32'hCAFEF00D) begin n_bad++; $display("FAIL rel_write: got %h want cafef00d", ram[1]); end
        go_idle;
    endtask

    task automatic test_single_rw;
        logic [31:0] exp;
        m1_req = 1'b1; m1_addr = 32'd8; m1_wdata = 32'hDEADBEEF; m1_wenable = 4'hF;
        @(negedge clk);
        n_cmp++; if (m1_ready !== 1'b0) begin n_bad++; $display("FAIL rw_first: got %b want 0", m1_ready); end
        wait_edge;
        @(negedge clk);
        n_cmp++; if (m1_ready !== 1'b1) begin n_bad++; $display("FAIL rw_wready: got %b want 1", m1_ready); end
        n_cmp++; if (m0_ready !== 1'b0) begin n_bad++; $display("FAIL rw_m0idle: got %b want 0", m0_ready); end
        wait_edge;
        m1_wenable = 4'h0;
        exp_data_q.push_back(32'hDEADBEEF);
        @(negedge clk);
        n_cmp++; if (ram[2] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rw_ram: got %h want deadbeef", ram[2]); end
        n_cmp++;
        if (m1_ready !== 1'b1) begin
            n_bad++; $display("FAIL rw_rready: got %b want 1", m1_ready);
        end else begin
            exp = exp_data_q.pop_front();
            if (m1_rdata !== exp) begin n_bad++; $display("FAIL rw_rdata: got %h want %h", m1_rdata, exp); end
        end
        go_idle;
    endtask

    task automatic test_tie;
        logic [1:0] exp;
        do_reset;
        for (int i = 0; i < 12; i++) exp_grant_q.push_back((i >= 4 && i < 8) ? 2'b10 : 2'b01);
        m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'd0; m1_addr = 32'd4;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (m0_ready || m1_ready) begin
                n_cmp++;
                if (exp_grant_q.size() == 0) begin
                    n_bad++; $display("FAIL tie_extra: got %b%b want none", m1_ready, m0_ready);
                end else begin
                    exp = exp_grant_q.pop_front();
                    if ({m1_ready, m0_ready} !== exp) begin
                        n_bad++; $display("FAIL tie_grant c%0d: got %b%b want %b", c, m1_ready, m0_ready, exp);
                    end
                end
            end
            wait_edge;
        end
        n_cmp++; if (exp_grant_q.size() != 0) begin n_bad++; $display("FAIL tie_left: got %0d want 0", exp_grant_q.size()); end
        exp_grant_q.delete();
        go_idle;
    endtask

    task automatic test_byte_enable;
        m0_req = 1'b1; m0_addr = 32'd0; m0_wdata = 32'h11223344; m0_wenable = 4'hF;
        @(negedge clk);
        n_cmp++; if (m1_ready !== 1'b0) begin n_bad++; $display("FAIL be_m1a: got %b want 0", m1_ready); end
        wait_edge;
        @(negedge clk);
        n_cmp++; if (m0_ready !== 1'b1) begin n_bad++; $display("FAIL be_full: got %b want 1", m0_ready); end
        wait_edge;
        m0_wdata = 32'h0000AB00; m0_wenable = 4'b0010;
        @(negedge clk);
        n_cmp++; if (mem_wenable !== 4'b0010) begin n_bad++; $display("FAIL be_wen: got %b want 0010", mem_wenable); end
        n_cmp++; if (m1_ready !== 1'b0) begin n_bad++; $display("FAIL be_m1b: got %b want 0", m1_ready); end
        wait_edge;
        m0_req = 1'b0; m0_wenable = '0;
        @(negedge clk);
        n_cmp++; if (ram[0] !== 32'h1122AB44) begin n_bad++; $display("FAIL be_word: got %h want 1122ab44", ram[0]); end
        go_idle;
    endtask

    task automatic test_release_idle;
        logic [31:0] exp;
        m0_req = 1'b1; m0_addr = 32'd12; m0_wdata = 32'h55AA55AA; m0_wenable = 4'hF;
        wait_edge;
        @(negedge clk);
        n_cmp++; if (m0_ready !== 1'b1) begin n_bad++; $display("FAIL rel_m0: got %b want 1", m0_ready); end
        wait_edge;
        m0_req = 1'b0; m0_wdata = 32'h99999999;
        @(negedge clk);
        n_cmp++; if (mem_wenable !== 4'h0) begin n_bad++; $display("FAIL drop_wen: got %h want 0", mem_wenable); end
        wait_edge;
        @(negedge clk);
        n_cmp++; if (owner !== 2'b00) begin n_bad++; $display("FAIL idle_owner: got %b want 00", owner); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL idle_addr: got %h want 0", mem_addr); end
        n_cmp++; if (mem_wenable !== 4'h0) begin n_bad++; $display("FAIL idle_wen: got %h want 0", mem_wenable); end
        n_cmp++; if (ram[3] !== 32'h55AA55AA) begin n_bad++; $display("FAIL drop_ram: got %h want 55aa55aa", ram[3]); end
        m0_wenable = '0;
        wait_edge;
        wait_edge;
        m1_req = 1'b1; m1_addr = 32'd4; m1_wenable = 4'h0;
        exp_data_q.push_back(32'hCAFEF00D);
        @(negedge clk);
        n_cmp++; if (m1_ready !== 1'b0) begin n_bad++; $display("FAIL rel_m1early: got %b want 0", m1_ready); end
        wait_edge;
        @(negedge clk);
        n_cmp++;
        if (m1_ready !== 1'b1) begin
            n_bad++; $display("FAIL rel_m1ready: got %b want 1", m1_ready);
        end else begin
            exp = exp_data_q.pop_front();
            if (m1_rdata !== exp) begin n_bad++; $display("FAIL rel_rdata: got %h want %h", m1_rdata, exp); end
        end
        go_idle;
    endtask

    task automatic test_async_reset;
        m0_req = 1'b1; m0_addr = 32'd20; m0_wdata = 32'h12345678; m0_wenable = 4'hF;
        wait_edge;
        @(negedge clk);
        n_cmp++; if (mem_wenable !== 4'hF) begin n_bad++; $display("FAIL ar_pre: got %h want f", mem_wenable); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_wenable !== 4'h0) begin n_bad++; $display("FAIL ar_wen: got %h want 0", mem_wenable); end
        n_cmp++; if (m0_ready !== 1'b0) begin n_bad++; $display("FAIL ar_ready: got %b want 0", m0_ready); end
        n_cmp++; if (owner !== 2'b00) begin n_bad++; $display("FAIL ar_owner: got %b want 00", owner); end
        wait_edge;
        m0_req = 1'b0; m0_wenable = '0;
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (ram[5] === 32'h12345678) begin n_bad++; $display("FAIL ar_ram: got %h want unwritten", ram[5]); end
        go_idle;
    endtask

    task automatic test_starvation;
        logic [1:0] exp;
        int c0, c1;
        c0 = 0; c1 = 0;
        do_reset;
        for (int i = 0; i < 10; i++) exp_grant_q.push_back(i[0] ? 2'b10 : 2'b01);
        m0_req = 1'b1; m1_req = 1'b1; m0_wenable = '0; m1_wenable = '0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (h1_m0_ready) c0++;
            if (h1_m1_ready) c1++;
            if (h1_m0_ready || h1_m1_ready) begin
                n_cmp++;
                if (exp_grant_q.size() == 0) begin
                    n_bad++; $display("FAIL sv_extra: got %b%b want none", h1_m1_ready, h1_m0_ready);
                end else begin
                    exp = exp_grant_q.pop_front();
                    if ({h1_m1_ready, h1_m0_ready} !== exp) begin
                        n_bad++; $display("FAIL sv_grant c%0d: got %b%b want %b", c, h1_m1_ready, h1_m0_ready, exp);
                    end
                end
            end
            wait_edge;
        end
        n_cmp++; if (c0 != 5) begin n_bad++; $display("FAIL sv_m0cnt: got %0d want 5", c0); end
        n_cmp++; if (c1 != 5) begin n_bad++; $display("FAIL sv_m1cnt: got %0d want 5", c1); end
        exp_grant_q.delete();
        go_idle;
    endtask

    initial begin
        test_reset;
        test_single_rw;
        test_tie;
        test_byte_enable;
        test_release_idle;
        test_async_reset;
        test_starvation;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single data port of simple_ram between two requesters:
  - M0: the cpu data port.
  - M1: a loader/DMA/debug master.
- Registered-ownership arbiter with round-robin tie-break and a bounded hold time, so neither master starves.
- Sits between the masters and simple_ram. Masters wait on a per-master ready; the cpu uses its ready as a stall qualifier.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; DATA_WIDTH/8 byte-enable bits.
- MAX_HOLD, 4, max consecutive served cycles for one owner while the other requests; legal range >=1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_req  in  1  M0 access request, held until served.
- m0_addr  in  ADDR_WIDTH  M0 byte address.
- m0_wdata  in  DATA_WIDTH  M0 write data.
- m0_wenable  in  DATA_WIDTH/8  M0 byte write enables; all zero means read.
- m0_ready  out  1  M0 access performed this cycle.
- m0_rdata  out  DATA_WIDTH  read data, valid when m0_ready.
- m1_req, m1_addr, m1_wdata, m1_wenable, m1_ready, m1_rdata: identical set for M1.
- mem_addr  out  ADDR_WIDTH  to simple_ram addr.
- mem_wdata  out  DATA_WIDTH  to simple_ram wdata.
- mem_wenable  out  DATA_WIDTH/8  to simple_ram wenable.
- mem_rdata  in  DATA_WIDTH  from simple_ram rdata (combinational read).
- owner  out  2  current owner: 00 idle, 01 M0, 10 M1.

Behaviour:
- State registers:
  - owner: IDLE/OWN_M0/OWN_M1.
  - last: last master served, 1 bit.
  - hold_cnt: width clog2(MAX_HOLD)+1.
- Reset (async, rst_n low): owner=IDLE, last=1 (M0 wins first tie), hold_cnt=0.
  - All outputs are combinational from state, so during reset: m0_ready=m1_ready=0, mem_wenable=0, mem_addr=0, mem_wdata=0, owner=00.
- Serving (combinational): mX_ready = mX_req && owner==OWN_MX.
  - The mem_* outputs mux the owner's addr/wdata/wenable.
  - mem_wenable is forced to 0 unless the owner's ready=1.
  - IDLE drives all mem_* to 0.
- Read data: m0_rdata = m1_rdata = mem_rdata, unconditionally. Masters ignore it unless ready.
- Writes: committed by simple_ram on the rising edge ending a ready cycle.
- Next owner, evaluated at each rising edge:
  - IDLE:
    - only one requests -> that master.
    - both request -> the master != last.
    - none -> IDLE.
  - OWN_MX:
    - own req and (other not requesting, or hold_cnt < MAX_HOLD-1) -> stay; hold_cnt+1, saturating.
    - otherwise, if other requests -> switch to other; hold_cnt=0.
    - own req dropped and other idle -> IDLE; hold_cnt=0.
  - last := X on every edge where mX_ready was 1.
- Latency:
  - From IDLE: first ready one cycle after req rises.
  - Continuing owner: one access per cycle, back-to-back.
  - Switch cost: zero bubble cycles. The other master is served in the cycle immediately after the handover edge.
- Hold limit: with both requesting continuously, service alternates in runs of exactly MAX_HOLD cycles. With MAX_HOLD=1 it alternates every cycle.
- Owner stays while its req=1 even if it is re-requesting a different address; each ready cycle is one access.
- Req deasserted while owner (no ready that cycle): no memory side effect. Ownership is released at the next edge per the rules above.
- Reset mid-access: the pending write is dropped (wenable forced 0 asynchronously). The master must re-request after reset.
- Addresses pass through unchanged. Alignment and mapping are simple_ram's concern.

Decomposition:
- Package mem_arb_pkg holds:
  - owner encoding constants OWN_IDLE=2'b00, OWN_M0=2'b01, OWN_M1=2'b10.
  - default MAX_HOLD.
- One sub-module, mem_arb_fsm: owner/last/hold_cnt registers and next-owner logic. Inputs are the two reqs; output is owner.
- The top contains only the request/data muxing and ready generation.

Test Plan:
- Reset hold: rst_n=0 with m0_req=1, m0_wenable=4'hF -> mem_wenable=0, m0_ready=0, owner=00. After release, owner=01 at the first edge and m0_ready=1 next cycle.
- Single master write/read: M1 writes 32'hDEADBEEF to addr 8 with wenable=4'hF, then reads addr 8 -> m1_ready high one cycle after req, ram word 2 = DEADBEEF, m1_rdata=DEADBEEF during the read's ready cycle.
- Tie from idle after reset: m0_req and m1_req rise together -> owner=01 first. With MAX_HOLD=4 and both held, the ready pattern is M0×4, M1×4, M0×4.
- Byte enable passthrough: M0 wenable=4'b0010, wdata=32'h0000AB00 to addr 0 over an initial word of 32'h11223344 -> word becomes 32'h1122AB44. m1 sees m1_ready=0 throughout.
- Release to idle: owner M0 drops req, M1 idle -> owner=00 at the next edge, mem_wenable=0, mem_addr=0. M1 requests 2 cycles later -> m1_ready one cycle after.
- Starvation bound: with MAX_HOLD=1 and both requesting for 10 cycles -> ready strictly alternates, 5 accesses each, and no cycle has both readys high.
